alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Issue stage for a single-cycle external ALU: decodes one RV32I ALU instruction,
// drives registered operands/select, captures the result and holds it for writeback.
module alu_issue_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_opA,
    output logic [XLEN-1:0] alu_opB,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_we,
    output logic            out_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_XOR  = 4'b0010;
    localparam logic [3:0] SEL_OR   = 4'b0011;
    localparam logic [3:0] SEL_AND  = 4'b0100;
    localparam logic [3:0] SEL_SLT  = 4'b0101;
    localparam logic [3:0] SEL_SLTU = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_SRL  = 4'b1000;

    state_t state, state_next;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] shamt_i;
    logic [XLEN-1:0] shamt_r;
    logic            dec_legal;
    logic [3:0]      dec_sel;
    logic [XLEN-1:0] dec_opb;
    logic            accept;
    logic            unused_fields;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign rd      = in_instr[11:7];
    assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign shamt_i = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign shamt_r = {{(XLEN-5){1'b0}}, in_rs2[4:0]};

    // rs1 is supplied already read, so the rs1 index field is not needed here
    assign unused_fields = ^in_instr[19:15];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);

    // Instruction decode into ALU select and operand B
    always_comb begin
        dec_legal = 1'b0;
        dec_sel   = SEL_ADD;
        dec_opb   = '0;
        case (opcode)
            7'b0110011: begin
                dec_opb = in_rs2;
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000: dec_sel = SEL_ADD;
                        3'b100: dec_sel = SEL_XOR;
                        3'b110: dec_sel = SEL_OR;
                        3'b111: dec_sel = SEL_AND;
                        3'b010: dec_sel = SEL_SLT;
                        3'b011: dec_sel = SEL_SLTU;
                        3'b001: begin dec_sel = SEL_SLL; dec_opb = shamt_r; end
                        3'b101: begin dec_sel = SEL_SRL; dec_opb = shamt_r; end
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_sel   = SEL_SUB;
                end
            end
            7'b0010011: begin
                dec_legal = 1'b1;
                dec_opb   = imm_i;
                case (funct3)
                    3'b000: dec_sel = SEL_ADD;
                    3'b100: dec_sel = SEL_XOR;
                    3'b110: dec_sel = SEL_OR;
                    3'b111: dec_sel = SEL_AND;
                    3'b010: dec_sel = SEL_SLT;
                    3'b011: dec_sel = SEL_SLTU;
                    3'b001: begin
                        dec_sel   = SEL_SLL;
                        dec_opb   = shamt_i;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_sel   = SEL_SRL;
                        dec_opb   = shamt_i;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Illegal instructions skip EXEC since there is no result to capture
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = dec_legal ? EXEC : DONE;
            EXEC:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opA     <= '0;
            alu_opB     <= '0;
            alu_sel     <= '0;
            out_rd      <= '0;
            out_data    <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_rd      <= rd;
            out_data    <= '0;
            out_we      <= dec_legal && (rd != 5'd0);
            out_illegal <= ~dec_legal;
            // An illegal op leaves the previous ALU operands untouched
            if (dec_legal) begin
                alu_opA <= in_rs1;
                alu_opB <= dec_opb;
                alu_sel <= dec_sel;
            end
        end else if (state == EXEC) begin
            out_data <= alu_result;
        end
    end

endmodule
